video_adc_frontend: RTL and testbench

VIDEO_ADC_FRONTEND -- requirements
Module: video_adc_frontend

---
 rtl/video_pkg.sv | 23 ++
 rtl/gain_offset_sat.sv | 69 ++++++
 rtl/video_adc_frontend.sv | 147 ++++++++++++++
 tb/tb_video_adc_frontend.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared defaults, coefficient reset values and output saturation for the video ADC front end.
package video_pkg;

    localparam int unsigned ADC_W_DEF  = 12;
    localparam int unsigned OUT_W_DEF  = 13;
    localparam int unsigned COEF_W_DEF = 15;

    localparam int CONTRAST_RST   = 1;
    localparam int BRIGHTNESS_RST = 0;

    // Clamp v to the two's-complement range of a w-bit signed value (w <= 63).
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                        input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/gain_offset_sat.sv
// Shared arithmetic pipeline: stage 2 forms the full-width gain product, stage 3 removes the
// brightness offset and saturates to OUT_W. The channel tag and valid ride alongside the data.
module gain_offset_sat
    import video_pkg::*;
#(
    parameter int unsigned ADC_W  = ADC_W_DEF,
    parameter int unsigned OUT_W  = OUT_W_DEF,
    parameter int unsigned COEF_W = COEF_W_DEF,
    parameter int unsigned CH_W   = 1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     in_valid,
    input  logic [CH_W-1:0]          in_ch,
    input  logic [ADC_W-1:0]         raw,
    input  logic [ADC_W-1:0]         floor_lvl,
    input  logic signed [COEF_W-1:0] contrast,
    input  logic signed [COEF_W-1:0] brightness,
    output logic                     out_valid,
    output logic [CH_W-1:0]          out_ch,
    output logic signed [OUT_W-1:0]  out_sample
);

    localparam int unsigned DIFF_W = ADC_W + 1;
    localparam int unsigned PROD_W = DIFF_W + COEF_W;
    localparam int unsigned BC_W   = 2 * COEF_W;
    localparam int unsigned SUM_W  = ((PROD_W > BC_W) ? PROD_W : BC_W) + 1;

    logic signed [DIFF_W-1:0] diff;
    logic signed [PROD_W-1:0] prod_d, prod_q;
    logic signed [BC_W-1:0]   bc_d, bc_q;
    logic signed [SUM_W-1:0]  sum;
    logic signed [OUT_W-1:0]  sat_d;
    logic                     s2_valid_q;
    logic [CH_W-1:0]          s2_ch_q;

    always_comb begin
        diff   = $signed({1'b0, raw}) - $signed({1'b0, floor_lvl});
        prod_d = PROD_W'(diff) * PROD_W'(contrast);
        bc_d   = BC_W'(brightness) * BC_W'(contrast);
        sum    = SUM_W'(prod_q) - SUM_W'(bc_q);
        sat_d  = OUT_W'(sat_to_width(64'(sum), OUT_W));
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s2_valid_q <= 1'b0;
            s2_ch_q    <= '0;
            prod_q     <= '0;
            bc_q       <= '0;
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_sample <= '0;
        end else begin
            s2_valid_q <= in_valid;
            if (in_valid) begin
                prod_q  <= prod_d;
                bc_q    <= bc_d;
                s2_ch_q <= in_ch;
            end
            out_valid <= s2_valid_q;
            if (s2_valid_q) begin
                out_sample <= sat_d;
                out_ch     <= s2_ch_q;
            end
        end
    end

endmodule

// File: rtl/video_adc_frontend.sv
// ADC front end: sample clock, channel sequencing, frame-synchronous coefficient shadowing and
// OTR counting. Define VIDEO_FRONTEND_OTR_HOLD_EN to substitute the channel's last good sample.
module video_adc_frontend
    import video_pkg::*;
#(
    parameter int unsigned ADC_W  = ADC_W_DEF,
    parameter int unsigned OUT_W  = OUT_W_DEF,
    parameter int unsigned COEF_W = COEF_W_DEF,
    parameter int unsigned DIV    = 2,
    parameter int unsigned NUM_CH = 1,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [ADC_W-1:0]         adc_in,
    input  logic                     adc_otr,
    output logic                     adc_clk,
    output logic [CH_W-1:0]          adc_ch_sel,
    input  logic [ADC_W-1:0]         floor_in,
    input  logic signed [COEF_W-1:0] contrast_in,
    input  logic signed [COEF_W-1:0] brightness_in,
    input  logic                     frame_sync,
    output logic signed [OUT_W-1:0]  out_sample,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_valid,
    output logic [15:0]              otr_count
);

    localparam int unsigned CNT_W = $clog2(DIV);

    logic [CNT_W-1:0]         div_cnt_q, div_cnt_d;
    logic                     adc_clk_q, adc_clk_d;
    logic [CH_W-1:0]          ch_sel_q, ch_sel_d;
    logic [15:0]              otr_cnt_q, otr_cnt_d;
    logic signed [COEF_W-1:0] contrast_act_q, brightness_act_q;
    logic                     strobe;
    logic                     otr_inc;
    logic [ADC_W-1:0]         raw_sel;

    logic                     s1_valid_q;
    logic [CH_W-1:0]          s1_ch_q;
    logic [ADC_W-1:0]         s1_raw_q, s1_floor_q;
    logic signed [COEF_W-1:0] s1_contrast_q, s1_brightness_q;

    always_comb begin
        strobe    = (div_cnt_q == CNT_W'(DIV - 1));
        div_cnt_d = strobe ? '0 : div_cnt_q + CNT_W'(1);
        adc_clk_d = (div_cnt_d < CNT_W'(DIV / 2));

        ch_sel_d = ch_sel_q;
        if (strobe) begin
            ch_sel_d = (ch_sel_q == CH_W'(NUM_CH - 1)) ? '0 : ch_sel_q + CH_W'(1);
        end

        // A frame_sync that lands on an OTR strobe restarts the count at one, not zero.
        otr_inc   = strobe & adc_otr;
        otr_cnt_d = otr_cnt_q;
        if (frame_sync) begin
            otr_cnt_d = otr_inc ? 16'd1 : 16'd0;
        end else if (otr_inc && (otr_cnt_q != 16'hFFFF)) begin
            otr_cnt_d = otr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            div_cnt_q        <= '0;
            adc_clk_q        <= 1'b1;
            ch_sel_q         <= '0;
            otr_cnt_q        <= '0;
            contrast_act_q   <= COEF_W'(CONTRAST_RST);
            brightness_act_q <= COEF_W'(BRIGHTNESS_RST);
        end else begin
            div_cnt_q <= div_cnt_d;
            adc_clk_q <= adc_clk_d;
            ch_sel_q  <= ch_sel_d;
            otr_cnt_q <= otr_cnt_d;
            if (frame_sync) begin
                contrast_act_q   <= contrast_in;
                brightness_act_q <= brightness_in;
            end
        end
    end

`ifdef VIDEO_FRONTEND_OTR_HOLD_EN
    logic [ADC_W-1:0] last_good_q [2**CH_W];

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < 2**CH_W; i++) begin
                last_good_q[i] <= '0;
            end
        end else if (strobe && !adc_otr) begin
            last_good_q[ch_sel_q] <= adc_in;
        end
    end

    assign raw_sel = adc_otr ? last_good_q[ch_sel_q] : adc_in;
`else
    assign raw_sel = adc_in;
`endif

    // Floor and coefficients travel with the sample so a mid-pipeline frame_sync cannot split them.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1_valid_q      <= 1'b0;
            s1_ch_q         <= '0;
            s1_raw_q        <= '0;
            s1_floor_q      <= '0;
            s1_contrast_q   <= '0;
            s1_brightness_q <= '0;
        end else begin
            s1_valid_q <= strobe;
            if (strobe) begin
                s1_ch_q         <= ch_sel_q;
                s1_raw_q        <= raw_sel;
                s1_floor_q      <= floor_in;
                s1_contrast_q   <= contrast_act_q;
                s1_brightness_q <= brightness_act_q;
            end
        end
    end

    gain_offset_sat #(
        .ADC_W  (ADC_W),
        .OUT_W  (OUT_W),
        .COEF_W (COEF_W),
        .CH_W   (CH_W)
    ) u_gain_offset_sat (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .in_valid   (s1_valid_q),
        .in_ch      (s1_ch_q),
        .raw        (s1_raw_q),
        .floor_lvl  (s1_floor_q),
        .contrast   (s1_contrast_q),
        .brightness (s1_brightness_q),
        .out_valid  (out_valid),
        .out_ch     (out_ch),
        .out_sample (out_sample)
    );

    assign adc_clk    = adc_clk_q;
    assign adc_ch_sel = ch_sel_q;
    assign otr_count  = otr_cnt_q;

endmodule

// File: tb/tb_video_adc_frontend.sv
// Bench for video_adc_frontend: a default instance (DIV=2, 1 channel) and a DIV=4, 3-channel
// instance share stimulus; both are compared each cycle against a cycle-indexed reference model.
module tb_video_adc_frontend;

    logic               sys_clk;
    logic               sys_rst;
    logic [11:0]        adc_in;
    logic               adc_otr;
    logic [11:0]        floor_in;
    logic signed [14:0] contrast_in;
    logic signed [14:0] brightness_in;
    logic               frame_sync;

    logic               adc_clk0, adc_clk1;
    logic [0:0]         sel0, ch0;
    logic [1:0]         sel1, ch1;
    logic signed [12:0] smp0, smp1;
    logic               vld0, vld1;
    logic [15:0]        otr0, otr1;

    video_adc_frontend #(.DIV(2), .NUM_CH(1)) dut0 (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .adc_in        (adc_in),
        .adc_otr       (adc_otr),
        .adc_clk       (adc_clk0),
        .adc_ch_sel    (sel0),
        .floor_in      (floor_in),
        .contrast_in   (contrast_in),
        .brightness_in (brightness_in),
        .frame_sync    (frame_sync),
        .out_sample    (smp0),
        .out_ch        (ch0),
        .out_valid     (vld0),
        .otr_count     (otr0)
    );

    video_adc_frontend #(.DIV(4), .NUM_CH(3)) dut1 (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .adc_in        (adc_in),
        .adc_otr       (adc_otr),
        .adc_clk       (adc_clk1),
        .adc_ch_sel    (sel1),
        .floor_in      (floor_in),
        .contrast_in   (contrast_in),
        .brightness_in (brightness_in),
        .frame_sync    (frame_sync),
        .out_sample    (smp1),
        .out_ch        (ch1),
        .out_valid     (vld1),
        .otr_count     (otr1)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Drive values applied at the next cycle() call.
    logic [11:0]        drv_adc;
    logic               drv_otr;
    logic [11:0]        drv_floor;
    logic signed [14:0] drv_contrast;
    logic signed [14:0] drv_brightness;
    logic               drv_fs;

    // Reference model state; m counts rising edges since reset release.
    int     m;
    bit     pv[2][4];
    longint ps[2][4];
    int     pc[2][4];
    longint hold_s[2];
    int     hold_c[2];
    int     ocnt[2];
    longint lg[2][4];
    longint act_c, act_b;

    function automatic int div_of(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic int nch_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic check_eq(input string tag, input logic signed [63:0] got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m     = 0;
        act_c = 1;
        act_b = 0;
        for (int i = 0; i < 2; i++) begin
            hold_s[i] = 0;
            hold_c[i] = 0;
            ocnt[i]   = 0;
            for (int j = 0; j < 4; j++) begin
                pv[i][j] = 1'b0;
                lg[i][j] = 0;
            end
        end
    endtask

    // Model of one clock cycle n = m with the drive values currently applied.
    task automatic model_step();
        int     d, nc, ch;
        bit     stb;
        longint raw, val;
        for (int i = 0; i < 2; i++) begin
            d   = div_of(i);
            nc  = nch_of(i);
            stb = ((m % d) == d - 1);
            if (stb) begin
                ch  = (m / d) % nc;
                raw = longint'(drv_adc);
`ifdef VIDEO_FRONTEND_OTR_HOLD_EN
                if (drv_otr) raw = lg[i][ch];
                else lg[i][ch] = raw;
`endif
                val = (raw - longint'(drv_floor)) * act_c - act_b * act_c;
                if (val > 4095) val = 4095;
                else if (val < -4096) val = -4096;
                pv[i][m % 4] = 1'b1;
                ps[i][m % 4] = val;
                pc[i][m % 4] = ch;
            end
            if (drv_fs) ocnt[i] = (stb && drv_otr) ? 1 : 0;
            else if (stb && drv_otr && ocnt[i] < 65535) ocnt[i]++;
        end
        if (drv_fs) begin
            act_c = longint'(drv_contrast);
            act_b = longint'(drv_brightness);
        end
    endtask

    task automatic check_inst(input int i, input logic v, input logic signed [12:0] s,
                              input logic [1:0] ch, input logic aclk, input logic [1:0] sel,
                              input logic [15:0] oc);
        int d, nc, slot;
        bit ev;
        d  = div_of(i);
        nc = nch_of(i);
        ev = 1'b0;
        if (m >= 3) begin
            slot = (m - 3) % 4;
            if (pv[i][slot]) begin
                ev          = 1'b1;
                pv[i][slot] = 1'b0;
                hold_s[i]   = ps[i][slot];
                hold_c[i]   = pc[i][slot];
            end
        end
        check_eq($sformatf("i%0d m%0d out_valid", i, m), v, longint'(ev));
        check_eq($sformatf("i%0d m%0d out_sample", i, m), s, hold_s[i]);
        check_eq($sformatf("i%0d m%0d out_ch", i, m), ch, hold_c[i]);
        check_eq($sformatf("i%0d m%0d adc_clk", i, m), aclk, ((m % d) < d / 2) ? 1 : 0);
        check_eq($sformatf("i%0d m%0d adc_ch_sel", i, m), sel, (m / d) % nc);
        check_eq($sformatf("i%0d m%0d otr_count", i, m), oc, ocnt[i]);
    endtask

    task automatic check_all();
        check_inst(0, vld0, smp0, {1'b0, ch0}, adc_clk0, {1'b0, sel0}, otr0);
        check_inst(1, vld1, smp1, ch1, adc_clk1, sel1, otr1);
    endtask

    task automatic cycle();
        adc_in        = drv_adc;
        adc_otr       = drv_otr;
        floor_in      = drv_floor;
        contrast_in   = drv_contrast;
        brightness_in = drv_brightness;
        frame_sync    = drv_fs;
        model_step();
        m++;
        @(negedge sys_clk);
        check_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic pulse_fs();
        drv_fs = 1'b1;
        cycle();
        drv_fs = 1'b0;
    endtask

    // Called at a falling edge; asserts reset asynchronously and releases two edges later.
    task automatic apply_reset();
        sys_rst = 1'b1;
        model_reset();
        #1;
        check_all();
        repeat (2) @(negedge sys_clk);
        check_all();
        sys_rst = 1'b0;
    endtask

    initial begin
        int tmp;
        sys_rst        = 1'b0;
        drv_adc        = '0;
        drv_otr        = 1'b0;
        drv_floor      = '0;
        drv_contrast   = 15'sd1;
        drv_brightness = '0;
        drv_fs         = 1'b0;
        adc_in         = '0;
        adc_otr        = 1'b0;
        floor_in       = '0;
        contrast_in    = 15'sd1;
        brightness_in  = '0;
        frame_sync     = 1'b0;
        #1;
        apply_reset();

        // Steady state, unsaturated gain of 512 * 4.
        drv_floor = 12'd200; drv_contrast = 15'sd4; drv_brightness = '0; drv_adc = 12'd712;
        pulse_fs();
        run(12);

        // Negative clamp.
        drv_adc = 12'd0; drv_floor = 12'd1000; drv_contrast = 15'sd8;
        pulse_fs();
        run(10);

        // Positive clamp with a negative brightness offset.
        drv_adc = 12'd4095; drv_floor = 12'd0; drv_contrast = 15'sd4; drv_brightness = -15'sd20;
        pulse_fs();
        run(10);

        // Coefficient shadowing: contrast_in changes mid-frame, then frame_sync on a strobe.
        drv_adc = 12'd712; drv_floor = 12'd200; drv_contrast = 15'sd4; drv_brightness = '0;
        pulse_fs();
        run(4);
        drv_contrast = 15'sd2;
        run(8);
        while (m % 4 != 3) cycle();
        pulse_fs();
        run(10);

        // Out-of-range handling: good sample 500, then OTR samples, then frame_sync clears.
        drv_contrast = 15'sd1; drv_floor = 12'd0;
        pulse_fs();
        drv_adc = 12'd500; drv_otr = 1'b0;
        run(8);
        drv_adc = 12'd4095; drv_otr = 1'b1;
        run(4);
        drv_adc = 12'd100; drv_otr = 1'b0;
        pulse_fs();
        run(6);

        // Reset one cycle after a strobe of the default instance.
        while (m < 4 || m % 2 != 0) cycle();
        apply_reset();
        run(12);

        // Randomized traffic with occasional frames, coefficient edits and one reset.
        for (int k = 0; k < 3000; k++) begin
            drv_adc = 12'($urandom_range(0, 4095));
            drv_otr = ($urandom_range(0, 7) == 0);
            drv_fs  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) begin
                tmp = int'($urandom_range(0, 24)) - 8;
                drv_contrast = 15'(tmp);
            end
            if ($urandom_range(0, 3) == 0) begin
                tmp = int'($urandom_range(0, 1000)) - 500;
                drv_brightness = 15'(tmp);
            end
            if ($urandom_range(0, 31) == 0) drv_floor = 12'($urandom_range(0, 4095));
            if (k == 1500) apply_reset();
            cycle();
        end
        drv_fs = 1'b0;
        drv_otr = 1'b0;
        run(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
